coin_acceptor: RTL and testbench

Input conditioning stage that sits directly upstream of the vending-machine controller and drives its `five` and `ten` coin inputs. It synchronizes and debounces two raw, asynchronous coin-slot buttons and detects their press edges. It arbitrates between the two slots and emits at most one single-cycle coin pulse per press. A post-pulse lockout window guarantees the controller never sees back-to-back or simultaneous coins.

---
 rtl/coin_acceptor_if.sv | 20 ++
 rtl/coin_acceptor.sv | 118 +++++++++++
 tb/tb_coin_acceptor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw button inputs and the conditioned coin pulses/status.
// The master side drives the buttons; the slave side produces the pulses.
interface coin_acceptor_if;
  logic       btn_five;
  logic       btn_ten;
  logic       five;
  logic       ten;
  logic       busy;
  logic [7:0] coin_tally;

  modport master (
    output btn_five, btn_ten,
    input  five, ten, busy, coin_tally
  );

  modport slave (
    input  btn_five, btn_ten,
    output five, ten, busy, coin_tally
  );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronizes, debounces and arbitrates two coin buttons into single-cycle coin pulses
// with a post-pulse lockout. Define COIN_TALLY_EN to build the saturating coin_tally register.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input logic            clk,
  input logic            rst,
  coin_acceptor_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StPulse, StLock} state_e;

  // Channel 0 is the five button, channel 1 the ten button.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DW-1:0] cnt_q [2];
  logic [1:0]    btn_raw;
  logic [1:0]    req;

  assign btn_raw = {bus.btn_ten, bus.btn_five};
  assign req     = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          // This edge is the one where the count reaches DEBOUNCE_CYCLES.
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  state_e        state_q;
  logic [LW-1:0] lock_q;
  logic          five_q, ten_q, busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lock_q  <= '0;
      five_q  <= 1'b0;
      ten_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req[1]) begin
            state_q <= StPulse;
            ten_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (req[0]) begin
            state_q <= StPulse;
            five_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StPulse: begin
          state_q <= StLock;
          lock_q  <= LW'(LOCKOUT_CYCLES);
          five_q  <= 1'b0;
          ten_q   <= 1'b0;
        end
        StLock: begin
          if (lock_q == LW'(1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            lock_q <= lock_q - LW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.five = five_q;
  assign bus.ten  = ten_q;
  assign bus.busy = busy_q;

`ifdef COIN_TALLY_EN
  logic [7:0] tally_q;
  logic [8:0] tally_sum;

  // five and ten are exclusive, so {ten, five} is the increment (0, 1 or 2).
  assign tally_sum = {1'b0, tally_q} + {7'd0, ten_q, five_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tally_q <= '0;
    else     tally_q <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
  end

  assign bus.coin_tally = tally_q;
`else
  assign bus.coin_tally = 8'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor at default parameters.
// Expected tally follows COIN_TALLY_EN when the bench is built with the same define.
module tb_coin_acceptor;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LOCK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   errors    = 0;
  int   five_n    = 0;
  int   ten_n     = 0;
  int   illegal   = 0;
  int   exp_tally = 0;
  logic prev_pulse = 1'b0;

  // Pulse counter plus exclusivity / back-to-back watchdog.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (bus.five) five_n <= five_n + 1;
      if (bus.ten)  ten_n  <= ten_n + 1;
      if ((bus.five && bus.ten) || ((bus.five || bus.ten) && prev_pulse)) illegal <= illegal + 1;
      prev_pulse <= bus.five | bus.ten;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tally_exp();
`ifdef COIN_TALLY_EN
    return 32'(exp_tally);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    bus.btn_five = 1'b0;
    bus.btn_ten  = 1'b0;
    #1;
    chk("rst_five", 32'(bus.five), 32'd0);
    chk("rst_ten", 32'(bus.ten), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tally", 32'(bus.coin_tally), 32'd0);
    step(2);
    rst = 1'b0;

    // Single held five press.
    bus.btn_five = 1'b1;
    step(6);
    chk("t1_five_edge6", 32'(bus.five), 32'd0);
    step(1);
    chk("t1_five_edge7", 32'(bus.five), 32'd1);
    chk("t1_ten_edge7", 32'(bus.ten), 32'd0);
    chk("t1_busy_edge7", 32'(bus.busy), 32'd1);
    step(1);
    chk("t1_five_edge8", 32'(bus.five), 32'd0);
    chk("t1_busy_edge8", 32'(bus.busy), 32'd1);
    step(7);
    chk("t1_busy_edge15", 32'(bus.busy), 32'd1);
    step(1);
    chk("t1_busy_edge16", 32'(bus.busy), 32'd0);
    step(34);
    exp_tally = 1;
    chk("t1_single_pulse", 32'(five_n), 32'd1);
    chk("t1_tally", 32'(bus.coin_tally), tally_exp());
    bus.btn_five = 1'b0;
    step(12);

    // Bouncing ten button, then settles high.
    bus.btn_ten = 1'b1; step(1);
    bus.btn_ten = 1'b0; step(1);
    bus.btn_ten = 1'b1; step(1);
    bus.btn_ten = 1'b0; step(1);
    bus.btn_ten = 1'b1;
    step(6);
    chk("t2_no_bounce_pulse", 32'(ten_n), 32'd0);
    chk("t2_ten_edge6", 32'(bus.ten), 32'd0);
    step(1);
    chk("t2_ten_edge7", 32'(bus.ten), 32'd1);
    exp_tally += 2;
    bus.btn_ten = 1'b0;
    step(20);
    chk("t2_one_pulse", 32'(ten_n), 32'd1);
    chk("t2_tally", 32'(bus.coin_tally), tally_exp());

    // Simultaneous presses: ten wins.
    bus.btn_five = 1'b1;
    bus.btn_ten  = 1'b1;
    step(7);
    chk("t3_ten", 32'(bus.ten), 32'd1);
    chk("t3_five", 32'(bus.five), 32'd0);
    step(20);
    exp_tally += 2;
    chk("t3_five_dropped", 32'(five_n), 32'd1);
    chk("t3_ten_count", 32'(ten_n), 32'd2);
    chk("t3_tally", 32'(bus.coin_tally), tally_exp());
    bus.btn_five = 1'b0;
    bus.btn_ten  = 1'b0;
    step(12);

    // Ten pressed so that its request lands inside the five lockout: dropped, never re-emitted.
    bus.btn_five = 1'b1;
    step(7);
    chk("t4_five", 32'(bus.five), 32'd1);
    exp_tally += 1;
    step(1);
    bus.btn_ten = 1'b1;
    step(20);
    chk("t4_ten_dropped", 32'(ten_n), 32'd2);
    chk("t4_busy_low", 32'(bus.busy), 32'd0);
    bus.btn_five = 1'b0;
    bus.btn_ten  = 1'b0;
    step(12);
    bus.btn_ten = 1'b1;
    step(7);
    chk("t4_fresh_ten", 32'(bus.ten), 32'd1);
    exp_tally += 2;
    bus.btn_ten = 1'b0;
    step(20);
    chk("t4_ten_count", 32'(ten_n), 32'd3);
    chk("t4_tally", 32'(bus.coin_tally), tally_exp());

    // Reset during the pulse cycle, button still held afterwards.
    bus.btn_five = 1'b1;
    step(7);
    chk("t5_five_before_rst", 32'(bus.five), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_five_async", 32'(bus.five), 32'd0);
    chk("t5_busy_async", 32'(bus.busy), 32'd0);
    chk("t5_tally_async", 32'(bus.coin_tally), 32'd0);
    exp_tally = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(6);
    chk("t5_five_edge6", 32'(bus.five), 32'd0);
    step(1);
    chk("t5_five_edge7", 32'(bus.five), 32'd1);
    exp_tally = 1;
    bus.btn_five = 1'b0;
    step(20);
    chk("t5_tally", 32'(bus.coin_tally), tally_exp());

`ifdef COIN_TALLY_EN
    // Saturation: 127 tens reach 254, one more gives 255, a five holds it.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 127; i++) begin
      bus.btn_ten = 1'b1;
      step(7);
      bus.btn_ten = 1'b0;
      step(12);
    end
    chk("t6_tally_254", 32'(bus.coin_tally), 32'd254);
    bus.btn_ten = 1'b1;
    step(7);
    bus.btn_ten = 1'b0;
    step(12);
    chk("t6_tally_255", 32'(bus.coin_tally), 32'd255);
    bus.btn_five = 1'b1;
    step(7);
    chk("t6_sat_five", 32'(bus.five), 32'd1);
    bus.btn_five = 1'b0;
    step(12);
    chk("t6_tally_hold", 32'(bus.coin_tally), 32'd255);
`endif

    chk("no_overlap_or_b2b", 32'(illegal), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
